// File: rtl/hs_ram_arbiter.sv
// Work-RAM port arbiter between the MC6809 bus and the MiSTer high-score interface.
// Freezes the CPU through its clock enable, lends the port to the high-score side, then hands it back.
module hs_ram_arbiter #(
    parameter int AW           = 11,
    parameter int GUARD_CYCLES = 2,
    parameter int SYNC_TIMEOUT = 64
) (
    input  logic          clk_49m,
    input  logic          reset,
    input  logic          pause,
    input  logic          cpu_cen_in,
    output logic          cpu_cen_out,
    output logic          cpu_hold,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    output logic [7:0]    cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_data_in,
    input  logic          hs_write,
    input  logic          hs_access,
    output logic [7:0]    hs_data_out,
    output logic          hs_ready
);

    localparam int SYNC_CW  = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam int GUARD_CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;

    localparam logic [SYNC_CW-1:0]  SYNC_LAST  = SYNC_CW'(SYNC_TIMEOUT - 1);
    localparam logic [SYNC_CW-1:0]  SYNC_MAX   = '1;
    localparam logic [GUARD_CW-1:0] GUARD_LAST = GUARD_CW'(GUARD_CYCLES - 1);
    localparam logic [GUARD_CW-1:0] GUARD_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [SYNC_CW-1:0]   r_sync_cnt;
    logic [GUARD_CW-1:0]  r_guard_cnt;
    logic [7:0]           r_hs_data;
    logic                 w_sync_done;
    logic                 w_guard_done;
    logic                 w_hs_owns;

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters idle at zero outside their state, so they are clear on entry; both saturate.
    always_ff @(posedge clk_49m) begin
        if (reset || r_state != SYNC) begin
            r_sync_cnt <= '0;
        end else if (r_sync_cnt != SYNC_MAX) begin
            r_sync_cnt <= r_sync_cnt + SYNC_CW'(1);
        end
    end

    always_ff @(posedge clk_49m) begin
        if (reset || r_state != RELEASE) begin
            r_guard_cnt <= '0;
        end else if (r_guard_cnt != GUARD_MAX) begin
            r_guard_cnt <= r_guard_cnt + GUARD_CW'(1);
        end
    end

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            r_hs_data <= 8'h00;
        end else if (r_state == GRANT) begin
            r_hs_data <= ram_dout;
        end
    end

    // A timed-out write still reaches RAM this cycle because the mux stays on the CPU in SYNC.
    assign w_sync_done  = !cpu_we || pause || (r_sync_cnt >= SYNC_LAST);
    assign w_guard_done = (r_guard_cnt >= GUARD_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (hs_access) w_state_next = SYNC;
            end
            SYNC: begin
                if (!hs_access)       w_state_next = RELEASE;
                else if (w_sync_done) w_state_next = GRANT;
            end
            GRANT: begin
                if (!hs_access) w_state_next = RELEASE;
            end
            RELEASE: begin
                if (w_guard_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Mux follows the current state, so a write coinciding with hs_access falling still lands.
    always_comb begin
        w_hs_owns   = (r_state == GRANT);
        cpu_hold    = (r_state != IDLE);
        hs_ready    = w_hs_owns;
        cpu_cen_out = cpu_cen_in & ~cpu_hold;
        cpu_rdata   = ram_dout;
        hs_data_out = r_hs_data;
        ram_addr    = cpu_addr;
        ram_din     = cpu_din;
        ram_we      = cpu_we;
        if (w_hs_owns) begin
            ram_addr = hs_address;
            ram_din  = hs_data_in;
            ram_we   = hs_write;
        end
    end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Scoreboard bench for hs_ram_arbiter with a behavioural synchronous work-RAM.
`timescale 1ns/1ps
module tb_hs_ram_arbiter;

    localparam int AW           = 11;
    localparam int GUARD_CYCLES = 2;
    localparam int SYNC_TIMEOUT = 64;

    logic          clk_49m = 1'b0;
    logic          reset = 1'b1;
    logic          pause = 1'b0;
    logic          cpu_cen_in = 1'b0;
    logic          cpu_cen_out;
    logic          cpu_hold;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = 8'h00;
    logic          cpu_we = 1'b0;
    logic [7:0]    cpu_rdata;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic [AW-1:0] hs_address = '0;
    logic [7:0]    hs_data_in = 8'h00;
    logic          hs_write = 1'b0;
    logic          hs_access = 1'b0;
    logic [7:0]    hs_data_out;
    logic          hs_ready;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    q_exp [$];
    int            checks = 0;
    int            errors = 0;
    int            cen_leak = 0;

    hs_ram_arbiter #(
        .AW(AW), .GUARD_CYCLES(GUARD_CYCLES), .SYNC_TIMEOUT(SYNC_TIMEOUT)
    ) dut (
        .clk_49m(clk_49m), .reset(reset), .pause(pause),
        .cpu_cen_in(cpu_cen_in), .cpu_cen_out(cpu_cen_out), .cpu_hold(cpu_hold),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .hs_address(hs_address), .hs_data_in(hs_data_in), .hs_write(hs_write),
        .hs_access(hs_access), .hs_data_out(hs_data_out), .hs_ready(hs_ready)
    );

    always #10 clk_49m = ~clk_49m;

    always @(posedge clk_49m) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout   <= mem[ram_addr];
        cpu_cen_in <= ~cpu_cen_in;
    end

    always @(negedge clk_49m) begin
        if (cpu_hold && cpu_cen_out) cen_leak++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_49m);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    // Present an address in GRANT; the value must appear on hs_data_out two edges later.
    task automatic hs_read(input logic [AW-1:0] a, input logic [7:0] e, input string nm);
        logic [7:0] exp_v;
        hs_address = a;
        q_exp.push_back(e);
        tick(2);
        checks++;
        if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            exp_v = q_exp.pop_front();
            if (hs_data_out !== exp_v) begin
                errors++;
                $display("FAIL %s hs_data_out got %h expected %h", nm, hs_data_out, exp_v);
            end
        end
    endtask

    task automatic enter_grant_quick();
        cpu_we = 1'b0; hs_access = 1'b1;
        tick(2);
    endtask

    task automatic leave_grant();
        hs_access = 1'b0;
        tick(1 + GUARD_CYCLES);
    endtask

    task automatic test_reset();
        logic c0;
        reset = 1'b1; hs_access = 1'b0;
        tick(3);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b expected 0", cpu_hold); end
        checks++; if (hs_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", hs_ready); end
        checks++; if (hs_data_out !== 8'h00) begin errors++; $display("FAIL reset_hsdata got %h expected 00", hs_data_out); end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            c0 = cpu_cen_in;
            checks++;
            if (cpu_cen_out !== c0) begin errors++; $display("FAIL idle_cen got %b expected %b", cpu_cen_out, c0); end
        end
    endtask

    task automatic test_basic_read();
        logic [7:0] exp_v;
        cpu_write(11'h123, 8'hA5);
        cpu_addr = 11'h123;
        q_exp.push_back(8'hA5);
        tick();
        exp_v = q_exp.pop_front();
        checks++; if (cpu_rdata !== exp_v) begin errors++; $display("FAIL cpu_rdata got %h expected %h", cpu_rdata, exp_v); end
        cen_leak = 0;
        hs_access = 1'b1;
        tick();
        checks++; if (cpu_hold !== 1'b1 || hs_ready !== 1'b0) begin errors++; $display("FAIL sync_state hold %b ready %b expected 1 0", cpu_hold, hs_ready); end
        tick();
        checks++; if (hs_ready !== 1'b1) begin errors++; $display("FAIL grant_ready got %b expected 1", hs_ready); end
        hs_read(11'h123, 8'hA5, "basic_read");
        hs_access = 1'b0;
        tick();
        checks++; if (cpu_hold !== 1'b1 || hs_ready !== 1'b0) begin errors++; $display("FAIL release_state hold %b ready %b expected 1 0", cpu_hold, hs_ready); end
        tick(GUARD_CYCLES);
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL release_end hold got %b expected 0", cpu_hold); end
        checks++; if (cen_leak !== 0) begin errors++; $display("FAIL cen_gate leaks got %0d expected 0", cen_leak); end
        checks++; if (hs_data_out !== 8'hA5) begin errors++; $display("FAIL hsdata_hold got %h expected a5", hs_data_out); end
    endtask

    task automatic test_write_strobe();
        cpu_addr = 11'h200; cpu_din = 8'h3C; cpu_we = 1'b1; hs_access = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (hs_ready !== 1'b0) begin errors++; $display("FAIL strobe_wait%0d ready got %b expected 0", i, hs_ready); end
            tick();
        end
        cpu_we = 1'b0;
        tick();
        checks++; if (hs_ready !== 1'b1) begin errors++; $display("FAIL strobe_grant ready got %b expected 1", hs_ready); end
        hs_address = 11'h010; hs_data_in = 8'h5A; hs_write = 1'b1;
        tick();
        hs_write = 1'b0;
        hs_read(11'h010, 8'h5A, "hs_write");
        hs_read(11'h200, 8'h3C, "cpu_write_lands");
        leave_grant();
    endtask

    task automatic test_timeout();
        int n;
        cpu_addr = 11'h300; cpu_din = 8'h77; cpu_we = 1'b1; hs_access = 1'b1;
        tick();
        n = 0;
        while (hs_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++; if (n != SYNC_TIMEOUT) begin errors++; $display("FAIL timeout_cycles got %0d expected %0d", n, SYNC_TIMEOUT); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL timeout_mux ram_we got %b expected 0", ram_we); end
        cpu_we = 1'b0;
        hs_read(11'h300, 8'h77, "timeout_write");
        leave_grant();
    endtask

    task automatic test_abort_release();
        int rdy_seen;
        cpu_write(11'h020, 8'h11);
        cpu_addr = 11'h021; cpu_din = 8'h22; cpu_we = 1'b1;
        hs_address = 11'h020; hs_data_in = 8'hEE; hs_write = 1'b1; hs_access = 1'b1;
        rdy_seen = 0;
        tick();
        if (hs_ready) rdy_seen++;
        hs_access = 1'b0;
        tick();
        if (hs_ready) rdy_seen++;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL abort_release hold got %b expected 1", cpu_hold); end
        tick(GUARD_CYCLES - 1);
        if (hs_ready) rdy_seen++;
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL abort_guard hold got %b expected 1", cpu_hold); end
        tick();
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL abort_idle hold got %b expected 0", cpu_hold); end
        checks++; if (rdy_seen != 0) begin errors++; $display("FAIL abort_ready pulses got %0d expected 0", rdy_seen); end
        hs_write = 1'b0; cpu_we = 1'b0;
        enter_grant_quick();
        hs_access = 1'b0;
        tick();
        hs_access = 1'b1;
        tick(GUARD_CYCLES - 1);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rearm_guard hold got %b expected 1", cpu_hold); end
        tick();
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rearm_idle hold got %b expected 0", cpu_hold); end
        tick();
        checks++; if (cpu_hold !== 1'b1 || hs_ready !== 1'b0) begin errors++; $display("FAIL rearm_sync hold %b ready %b expected 1 0", cpu_hold, hs_ready); end
        tick();
        checks++; if (hs_ready !== 1'b1) begin errors++; $display("FAIL rearm_grant ready got %b expected 1", hs_ready); end
        hs_read(11'h020, 8'h11, "abort_nowrite");
        leave_grant();
    endtask

    task automatic test_reset_grant();
        cpu_we = 1'b0;
        enter_grant_quick();
        hs_address = 11'h030; hs_data_in = 8'h99; hs_write = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL grant_we got %b expected 1", ram_we); end
        reset = 1'b1;
        tick();
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_grant_we got %b expected 0", ram_we); end
        checks++; if (cpu_hold !== 1'b0 || hs_ready !== 1'b0) begin errors++; $display("FAIL rst_grant_state hold %b ready %b expected 0 0", cpu_hold, hs_ready); end
        checks++; if (hs_data_out !== 8'h00) begin errors++; $display("FAIL rst_grant_hsdata got %h expected 00", hs_data_out); end
        reset = 1'b0; hs_write = 1'b0; hs_access = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_strobe();
        test_timeout();
        test_abort_release();
        test_reset_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the main CPU work-RAM port between the MC6809 bus and the MiSTer high-score interface (hs_address/hs_data_in/hs_data_out/hs_write/hs_access).
- Freezes the CPU by gating its clock enable, grants the RAM port to the high-score side, then returns it cleanly.
- Sits inside the main PCB between the CPU bus decode and the work-RAM instance.

Parameters:
- AW, 11, RAM address width (matches hs_address).
- GUARD_CYCLES, 2, clk_49m cycles the hold stays asserted after the port returns to the CPU.
- SYNC_TIMEOUT, 64, maximum clk_49m cycles spent waiting for a CPU write strobe to end.

Ports:
- clk_49m  in  1  system clock, 49.152 MHz
- reset  in  1  synchronous, active-high
- pause  in  1  core pause; when high the CPU is already frozen
- cpu_cen_in  in  1  raw CPU clock-enable pulse
- cpu_cen_out  out  1  gated enable to CPU: cpu_cen_in & ~cpu_hold
- cpu_hold  out  1  CPU freeze request
- cpu_addr  in  AW  CPU RAM address
- cpu_din  in  8  CPU write data
- cpu_we  in  1  CPU RAM write strobe (already qualified by chip select)
- cpu_rdata  out  8  RAM read data to the CPU (ram_dout pass-through)
- ram_addr  out  AW  RAM address
- ram_din  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  8  RAM read data, synchronous, 1-cycle latency
- hs_address  in  AW  high-score address
- hs_data_in  in  8  high-score write data
- hs_write  in  1  high-score write strobe
- hs_access  in  1  high-score access request (level)
- hs_data_out  out  8  high-score read data
- hs_ready  out  1  high when the high-score side owns the port

Behaviour:
- Reset values: state IDLE; cpu_hold=0; hs_ready=0; hs_data_out=0x00; ram_we follows the CPU mux (CPU side selected). Reset applies in any state, including mid-GRANT; ram_we from the high-score side is forced to 0 in the cycle after reset is sampled.
- Mux: in IDLE and SYNC, ram_addr/ram_din/ram_we come from the cpu_* inputs. In GRANT, they come from hs_address/hs_data_in/hs_write. In RELEASE, they come from the CPU side, and ram_we=cpu_we.
- cpu_rdata = ram_dout, combinational, in all states.
- FSM is 4 states, registered:
  - IDLE: cpu_hold=0. When hs_access=1 -> SYNC (cpu_hold=1 from the next cycle).
  - SYNC: cpu_hold=1, wait counter runs.
    - -> GRANT when (cpu_we=0 or pause=1), or when the counter reaches SYNC_TIMEOUT-1. On timeout the in-flight write is allowed to complete in that cycle, and the grant follows.
    - hs_access=0 while in SYNC -> RELEASE. No grant is issued and no high-score write is performed.
  - GRANT: cpu_hold=1, hs_ready=1.
    - hs_data_out <= ram_dout on every cycle, giving 2 cycles from hs_address change to valid hs_data_out.
    - hs_write in GRANT writes exactly on the cycles it is high.
    - hs_access=0 -> RELEASE. A hs_write arriving in the same cycle as hs_access falling is still performed, because the mux uses the current state.
  - RELEASE: cpu_hold=1, hs_ready=0, guard counter counts GUARD_CYCLES cycles, then -> IDLE with cpu_hold=0.
    - hs_access=1 again during RELEASE: finish the guard, pass through IDLE, then go to SYNC. At least one IDLE cycle is guaranteed.
- cpu_cen_out is combinational: cpu_cen_in & ~cpu_hold. No cpu_cen_out pulse occurs from the first SYNC cycle through the last RELEASE cycle.
- hs_write outside GRANT is ignored. hs_data_out holds its last value outside GRANT.
- pause does not change the FSM except in the SYNC exit condition. Holding across pause transitions is legal.
- Counters: the SYNC counter is 6 bits and the guard counter is 2 bits (sized from the parameters). Both clear on state entry and saturate; neither wraps.

Test Plan:
- Reset then idle: assert reset 3 cycles with hs_access=0 -> cpu_hold=0, hs_ready=0, hs_data_out=0x00, cpu_cen_out mirrors cpu_cen_in.
- Basic read: preload RAM[0x123]=0xA5; raise hs_access with cpu_we=0 -> SYNC 1 cycle, then hs_ready=1. Set hs_address=0x123 -> hs_data_out=0xA5 two cycles later, and no cpu_cen_out pulses while hold is high.
- Write during CPU strobe: cpu_we=1 held 5 cycles when hs_access rises -> grant only after cpu_we falls. CPU write data lands in RAM; hs_write of 0x5A to 0x010 -> RAM[0x010]=0x5A.
- Timeout: cpu_we stuck at 1 -> GRANT entered exactly SYNC_TIMEOUT cycles after SYNC entry.
- Abort and release: drop hs_access during SYNC -> no RAM write and no hs_ready pulse; hold drops 2 cycles after RELEASE entry. Re-raise hs_access during RELEASE -> one IDLE cycle, then SYNC.
- Reset mid-GRANT while hs_write=1 -> ram_we=0, state IDLE, cpu_hold=0 on the next cycle.
